// File: rtl/victim_write_buffer.sv
// Eviction buffer between the cache line port and the cacheline adaptor: dirty lines are
// acknowledged at once, fills bypass queued lines and buffered lines forward to matching fills.
module victim_write_buffer #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [255:0] mem_wdata,
    output logic [255:0] mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ACK, FILL, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [26:0]      tag_q  [DEPTH];
    logic [255:0]     line_q [DEPTH];
    logic [PTR_W-1:0] head, tail, hit_idx, walk;
    logic [CNT_W-1:0] count;
    logic             full, hit;
    logic             push, pop, load_hit, load_fill;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full = (count == CNT_W'(DEPTH));

    // Walk from oldest to newest so the last match wins: reads see the most recent eviction.
    always_comb begin
        hit     = 1'b0;
        hit_idx = head;
        walk    = head;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count && tag_q[walk] == mem_address[31:5]) begin
                hit     = 1'b1;
                hit_idx = walk;
            end
            walk = ptr_inc(walk);
        end
    end

    assign push      = (state == IDLE) && !mem_read && mem_write && !full;
    assign pop       = (state == DRAIN) && pmem_resp;
    assign load_hit  = (state == IDLE) && mem_read && hit;
    assign load_fill = (state == FILL) && pmem_resp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read is checked first so an illegal read+write pair resolves as a read.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mem_read) begin
                    state_nxt = hit ? ACK : FILL;
                end else if (mem_write) begin
                    state_nxt = full ? DRAIN : ACK;
                end else if (count != '0) begin
                    state_nxt = DRAIN;
                end
            end
            ACK:     state_nxt = IDLE;
            FILL:    if (pmem_resp) state_nxt = ACK;
            DRAIN:   if (pmem_resp) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_resp     = (state == ACK);
        pmem_read    = (state == FILL);
        pmem_write   = (state == DRAIN);
        pmem_address = (state == FILL) ? {mem_address[31:5], 5'b0} : {tag_q[head], 5'b0};
        pmem_wdata   = line_q[head];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (push) begin
            tail  <= ptr_inc(tail);
            count <= count + 1'b1;
        end else if (pop) begin
            head  <= ptr_inc(head);
            count <= count - 1'b1;
        end
    end

    // Line storage carries no reset; validity is tracked solely by head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[tail]  <= mem_address[31:5];
            line_q[tail] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_rdata <= '0;
        end else if (load_hit) begin
            mem_rdata <= line_q[hit_idx];
        end else if (load_fill) begin
            mem_rdata <= pmem_rdata;
        end
    end

endmodule

// File: tb/tb_victim_write_buffer.sv
// Bench for victim_write_buffer: a FIFO-of-lines plus backing-memory model checked every
// cycle, with directed scenarios pinned by literal values and a randomized traffic phase.
module tb_victim_write_buffer;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         mem_read, mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata, mem_rdata;
    logic         mem_resp, pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    victim_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: buffered lines oldest-first, and the adaptor's backing memory.
    typedef struct packed { logic [26:0] tag; logic [255:0] line; } entry_t;
    typedef struct packed { logic wr; logic [31:0] addr; } ev_t;
    entry_t       model_q[$];
    ev_t          ev_log[$];
    logic [255:0] pmem_mem [logic [26:0]];

    function automatic logic [255:0] mem_val(input logic [26:0] t);
        if (pmem_mem.exists(t)) return pmem_mem[t];
        return {8{t, 5'b0}};
    endfunction

    function automatic bit find_newest(input logic [26:0] t, output logic [255:0] line);
        bit f = 1'b0;
        line = '0;
        foreach (model_q[i]) begin
            if (model_q[i].tag == t) begin
                f = 1'b1;
                line = model_q[i].line;
            end
        end
        return f;
    endfunction

    function automatic int count_reads();
        int n = 0;
        foreach (ev_log[i]) if (!ev_log[i].wr) n++;
        return n;
    endfunction

    // Adaptor: responds after adp_lat cycles (random 0..3 when negative), or never while stalled.
    int adp_lat   = 1;
    bit adp_stall = 1'b0;
    initial begin
        bit busy = 1'b0;
        int wait_cnt = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n || pmem_resp || !(pmem_read || pmem_write)) begin
                pmem_resp = 1'b0;
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    wait_cnt = (adp_lat < 0) ? int'($urandom_range(3, 0)) : adp_lat;
                end
                if (!adp_stall) begin
                    if (wait_cnt == 0) begin
                        pmem_resp = 1'b1;
                        if (pmem_read) pmem_rdata = mem_val(pmem_address[31:5]);
                        else pmem_mem[pmem_address[31:5]] = pmem_wdata;
                    end else begin
                        wait_cnt--;
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model.
    int cyc = 0;
    int presp_cyc = -10;
    bit prev_resp = 1'b0, prev_presp = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0, filled = 1'b0;
    logic [255:0] prev_rdata = '0;

    always @(negedge clk) begin : mon
        logic [255:0] exp_line;
        bit hit;
        cyc++;
        if (!reset_n) begin
            model_q.delete();
            prev_resp = 1'b0; prev_presp = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0;
            filled = 1'b0;
            prev_rdata = '0;
        end else begin
            check("pmem_exclusive", pmem_read && pmem_write, 0);
            if (pmem_read || pmem_write) check("pmem_addr_lsb", pmem_address[4:0], 0);
            if (prev_presp) check("pmem_drop_after_resp", {pmem_read, pmem_write}, 0);
            if (pmem_read) begin
                if (!prev_rd) ev_log.push_back('{1'b0, pmem_address});
                check("fill_addr", pmem_address, {mem_address[31:5], 5'b0});
                check("fill_has_read", mem_read, 1);
                hit = find_newest(mem_address[31:5], exp_line);
                check("fill_on_buffered_line", hit, 0);
                if (pmem_resp) begin
                    filled = 1'b1;
                    presp_cyc = cyc;
                end
            end
            if (pmem_write) begin
                if (!prev_wr) ev_log.push_back('{1'b1, pmem_address});
                check("drain_nonempty", model_q.size() != 0, 1);
                if (model_q.size() != 0) begin
                    check("drain_addr", pmem_address, {model_q[0].tag, 5'b0});
                    check("drain_data", pmem_wdata, model_q[0].line);
                    if (pmem_resp) void'(model_q.pop_front());
                end
            end
            if (mem_resp) begin
                check("resp_single_cycle", prev_resp, 0);
                check("resp_has_request", mem_read || mem_write, 1);
                if (mem_read) begin
                    hit = find_newest(mem_address[31:5], exp_line);
                    if (!hit) exp_line = mem_val(mem_address[31:5]);
                    check("read_data", mem_rdata, exp_line);
                    check("fill_iff_miss", filled, !hit);
                    if (filled) check("fill_resp_latency", cyc - presp_cyc, 1);
                    filled = 1'b0;
                end else if (mem_write) begin
                    check("push_has_space", model_q.size() < DEPTH, 1);
                    model_q.push_back('{mem_address[31:5], mem_wdata});
                end
            end else begin
                check("rdata_hold", mem_rdata, prev_rdata);
            end
            prev_resp  = mem_resp;
            prev_presp = pmem_resp;
            prev_rd    = pmem_read;
            prev_wr    = pmem_write;
            prev_rdata = mem_rdata;
        end
    end

    // Cache side; entered just after a rising edge, returns just after the edge leaving ACK.
    task automatic cache_req(input bit wr, input logic [31:0] addr, input logic [255:0] data,
                             output int lat);
        mem_write   = wr;
        mem_read    = !wr;
        mem_address = addr;
        if (wr) mem_wdata = data;
        lat = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (mem_resp) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_timeout: addr %h got no mem_resp, required one within 400 cycles", addr);
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drained();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (model_q.size() == 0 && !pmem_write && !pmem_read) break;
        end
        check("drained", model_q.size() == 0 && !pmem_write && !pmem_read, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_ev(input string name, input int idx, input bit wr, input logic [31:0] addr);
        logic [32:0] act = '1;
        if (idx < ev_log.size()) act = {ev_log[idx].wr, ev_log[idx].addr};
        check(name, act, {wr, addr});
    endtask

    initial begin
        int lat;
        int seen;
        logic [255:0] dx, dy, rnd;
        logic [31:0] addr;
        mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0;
        reset_n = 1'b0;

        @(negedge clk);
        check("rst_mem_resp", mem_resp, 0);
        check("rst_pmem_read", pmem_read, 0);
        check("rst_pmem_write", pmem_write, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single write, acked next cycle, then drained while idle.
        adp_lat = 1;
        ev_log.delete();
        cache_req(1'b1, 32'h0000_1020, {32{8'hA5}}, lat);
        check("t1_ack_latency", lat, 1);
        wait_drained();
        check("t1_drain_count", ev_log.size(), 1);
        check_ev("t1_drain_event", 0, 1'b1, 32'h0000_1020);
        check("t1_drained_line", mem_val(27'h81), {32{8'hA5}});
        idle(10);
        check("t1_no_more_drains", ev_log.size(), 1);

        // Duplicate tags with a stalled adaptor: read forwards the newest copy.
        adp_stall = 1'b1;
        ev_log.delete();
        dx = {8{32'h0BAD_F00D}};
        dy = {8{32'h600D_CAFE}};
        cache_req(1'b1, 32'h0000_0100, dx, lat);
        check("t2_ack_x", lat, 1);
        cache_req(1'b1, 32'h0000_0100, dy, lat);
        check("t2_ack_y", lat, 1);
        cache_req(1'b0, 32'h0000_0100, '0, lat);
        check("t2_hit_latency", lat, 1);
        check("t2_hit_data", mem_rdata, dy);
        check("t2_no_fill", count_reads(), 0);
        adp_stall = 1'b0;
        wait_drained();
        cache_req(1'b0, 32'h0000_0100, '0, lat);
        check("t2_refill_data", mem_rdata, dy);

        // Full buffer: third write drains the oldest first, then FIFO order across the wrap.
        adp_lat = 2;
        cache_req(1'b1, 32'h0000_01A0, {8{32'hAAAA_0001}}, lat);
        cache_req(1'b1, 32'h0000_02A0, {8{32'hBBBB_0002}}, lat);
        ev_log.delete();
        cache_req(1'b1, 32'h0000_0300, {8{32'hCCCC_0003}}, lat);
        check("t3_full_write_latency", lat, 5);
        check_ev("t3_first_drain", 0, 1'b1, 32'h0000_01A0);
        wait_drained();
        check_ev("t3_second_drain", 1, 1'b1, 32'h0000_02A0);
        check_ev("t3_third_drain", 2, 1'b1, 32'h0000_0300);
        ev_log.delete();
        cache_req(1'b1, 32'h0000_03A0, {8{32'hDDDD_0004}}, lat);
        cache_req(1'b1, 32'h0000_04A0, {8{32'hEEEE_0005}}, lat);
        cache_req(1'b0, 32'h0000_03A7, '0, lat);
        check("t3_wrap_hit_latency", lat, 1);
        check("t3_wrap_hit_data", mem_rdata, {8{32'hDDDD_0004}});
        wait_drained();
        check_ev("t3_wrap_drain0", 0, 1'b1, 32'h0000_03A0);
        check_ev("t3_wrap_drain1", 1, 1'b1, 32'h0000_04A0);

        // Fill bypasses a queued eviction.
        adp_lat = 1;
        ev_log.delete();
        cache_req(1'b1, 32'h0000_0200, {8{32'h1234_5678}}, lat);
        cache_req(1'b0, 32'h0000_0400, '0, lat);
        check("t4_fill_data", mem_rdata, {8{32'h0000_0400}});
        check_ev("t4_fill_first", 0, 1'b0, 32'h0000_0400);
        wait_drained();
        check_ev("t4_drain_after", 1, 1'b1, 32'h0000_0200);

        // Reset in the middle of a stalled drain.
        adp_stall = 1'b1;
        cache_req(1'b1, 32'h0000_0500, {8{32'h5555_AAAA}}, lat);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (pmem_write) begin
                seen = 1;
                break;
            end
        end
        check("t5_drain_started", seen, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_rst_pmem_write", pmem_write, 0);
        check("t5_rst_pmem_read", pmem_read, 0);
        check("t5_rst_mem_resp", mem_resp, 0);
        check("t5_rst_mem_rdata", mem_rdata, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        adp_stall = 1'b0;
        reset_n = 1'b1;
        ev_log.delete();
        idle(20);
        check("t5_quiet_after_reset", ev_log.size(), 0);

        // Randomized traffic over a small set of lines with random adaptor latency.
        adp_lat = -1;
        for (int n = 0; n < 300; n++) begin
            addr = 32'h0000_8000 + 32'($urandom_range(5, 0)) * 32 + 32'($urandom_range(31, 0));
            rnd  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            cache_req(bit'($urandom_range(1, 0)), addr, rnd, lat);
            idle(int'($urandom_range(3, 0)));
        end
        wait_drained();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
